// File: rtl/param_multimode_pingpong_counter.sv
// Bounded up/down counter with ping-pong, wrap-up, wrap-down and saturate modes,
// synchronous load and a registered one-cycle boundary pulse (turn).
module param_multimode_pingpong_counter #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              flip,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [1:0]        mode,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  max,
   input  logic [WIDTH-1:0]  min,
   output logic              direction,
   output logic [WIDTH-1:0]  out,
   output logic              turn
);

   localparam int XW = WIDTH + 1;

   localparam logic [1:0] MODE_PINGPONG  = 2'b00;
   localparam logic [1:0] MODE_WRAP_UP   = 2'b01;
   localparam logic [1:0] MODE_WRAP_DOWN = 2'b10;
   localparam logic [1:0] MODE_SATURATE  = 2'b11;

   logic [XW-1:0]    out_x;
   logic [XW-1:0]    min_x;
   logic [XW-1:0]    max_x;
   logic [XW-1:0]    step_x;
   logic [XW-1:0]    up_sum;
   logic [XW-1:0]    down_floor;
   logic [XW-1:0]    down_diff;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] down_val;
   logic             invalid;
   logic             dir_eff;
   logic             hit;
   logic             at_bound;

   logic [WIDTH-1:0] out_d;
   logic             dir_d;
   logic             turn_d;

   // One extra bit keeps out+step and min+step exact, so clamping never sees a wrapped sum.
   assign out_x      = {1'b0, out};
   assign min_x      = {1'b0, min};
   assign max_x      = {1'b0, max};
   assign step_x     = {{(XW-STEP_W){1'b0}}, step};
   assign up_sum     = out_x + step_x;
   assign down_floor = min_x + step_x;
   assign down_diff  = out_x - step_x;

   assign up_val   = (up_sum >= max_x)     ? max : up_sum[WIDTH-1:0];
   assign down_val = (out_x <= down_floor) ? min : down_diff[WIDTH-1:0];

   assign invalid = (max <= min) || (out < min) || (out > max) || (step == '0);

   // Flip takes effect on the same edge, so the step is computed in the flipped direction.
   assign dir_eff  = flip ? ~direction : direction;
   assign hit      = dir_eff ? (up_val == max) : (down_val == min);
   assign at_bound = dir_eff ? (out == max) : (out == min);

   always_comb begin
      out_d  = out;
      dir_d  = direction;
      turn_d = 1'b0;
      if (load) begin
         out_d = load_val;
      end else if (!enable || invalid) begin
         out_d = out;
      end else begin
         case (mode)
            MODE_WRAP_UP: begin
               dir_d = 1'b1;
               if (out == max) begin
                  out_d  = min;
                  turn_d = 1'b1;
               end else begin
                  out_d = up_val;
               end
            end
            MODE_WRAP_DOWN: begin
               dir_d = 1'b0;
               if (out == min) begin
                  out_d  = max;
                  turn_d = 1'b1;
               end else begin
                  out_d = down_val;
               end
            end
            MODE_PINGPONG: begin
               out_d = dir_eff ? up_val : down_val;
               dir_d = dir_eff;
               if (hit) begin
                  dir_d  = ~dir_eff;
                  turn_d = 1'b1;
               end
            end
            MODE_SATURATE: begin
               out_d = dir_eff ? up_val : down_val;
               dir_d = dir_eff;
               // Pulse only on arrival; sitting at the bound afterwards is silent.
               turn_d = hit && !at_bound;
            end
            default: begin
               out_d = out;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         direction <= 1'b1;
         turn      <= 1'b0;
      end else begin
         out       <= out_d;
         direction <= dir_d;
         turn      <= turn_d;
      end
   end

endmodule
